// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encoding and default widths for the pulse stretcher
//
// Purpose : state encoding and default parameter values, shared with the DMA
//           status/IRQ blocks that decode the stretcher's busy state.
// Contents: LEN_W_DEF, PEND_W_DEF, ps_state_e {ST_IDLE, ST_HIGH, ST_GAP}
package pulse_stretcher_pkg;

    localparam int LEN_W_DEF  = 8;
    localparam int PEND_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } ps_state_e;

endpackage

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event in / stretched level out bundle for the pulse stretcher
//
// Purpose : groups the event input, length controls and status outputs.
// Signals : pulse_in, pulse_len[LEN_W], gap_len[LEN_W]            (master -> slave)
//           level_out, busy, pending[PEND_W], overflow             (slave -> master)
// Modports: master (event source / consumer side), slave (pulse_stretcher)
interface pulse_stretcher_if
    import pulse_stretcher_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int PEND_W = PEND_W_DEF
) ();

    logic              pulse_in;
    logic [LEN_W-1:0]  pulse_len;
    logic [LEN_W-1:0]  gap_len;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse_in, pulse_len, gap_len,
        input  level_out, busy, pending, overflow
    );

    modport slave (
        input  pulse_in, pulse_len, gap_len,
        output level_out, busy, pending, overflow
    );

endinterface

// File: rtl/pulse_stretcher_sat_updown_counter.sv
// rtl/pulse_stretcher_sat_updown_counter.sv - saturating up/down event counter with overflow strobe
//
// Purpose : counts queued events; an increment at full scale is dropped and
//           reported as a one-cycle overflow pulse.
// Ports   : clk, rst (async, active-low), inc_i, dec_i,
//           count_o[W] (registered), overflow_o (registered one-cycle strobe)
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         overflow_o
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    // Simultaneous inc and dec cancel, so a full counter never drops an
    // event that is being consumed on the same cycle.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle events into gapped level pulses with an event queue
//
// Purpose : each pulse_in event becomes max(pulse_len,1) high cycles on
//           level_out, separated by at least gap_len low cycles; events that
//           arrive while busy are queued and replayed in order.
// Ports   : clk, rst (async, active-low), bus (pulse_stretcher_if.slave)
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pulse_stretcher_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    ps_state_e         state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic [LEN_W-1:0]  high_cnt;
    logic              eff_nz;
    logic              start;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    // Reload value for a HIGH phase; a zero length still yields one cycle.
    assign high_cnt = (bus.pulse_len == '0) ? '0 : bus.pulse_len - LEN_ONE;
    // An event is available if one is queued or one arrives this cycle.
    assign eff_nz   = bus.pulse_in | (pending != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.pulse_in) begin
                    start   = 1'b1;
                    state_d = ST_HIGH;
                    cnt_d   = high_cnt;
                end
            end
            ST_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_ONE;
                end else if (bus.gap_len != '0) begin
                    state_d = ST_GAP;
                    cnt_d   = bus.gap_len - LEN_ONE;
                end else if (eff_nz) begin
                    // No gap requested: chain straight into the next pulse.
                    start   = 1'b1;
                    state_d = ST_HIGH;
                    cnt_d   = high_cnt;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_ONE;
                end else if (eff_nz) begin
                    start   = 1'b1;
                    state_d = ST_HIGH;
                    cnt_d   = high_cnt;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // A start takes pulse_in first when present; inc/dec cancel in that case,
    // which also keeps pending at zero for a start out of IDLE.
    sat_updown_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (bus.pulse_in),
        .dec_i      (start),
        .count_o    (pending),
        .overflow_o (overflow)
    );

    assign bus.level_out = level_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.pending   = pending;
    assign bus.overflow  = overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher (PEND_W=4 and PEND_W=2 instances)
module tb_pulse_stretcher;
    import pulse_stretcher_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pulse_stretcher_if #(.LEN_W(8), .PEND_W(4)) ifa ();
    pulse_stretcher_if #(.LEN_W(8), .PEND_W(2)) ifb ();

    pulse_stretcher #(.LEN_W(8), .PEND_W(4)) dut   (.clk(clk), .rst(rst), .bus(ifa));
    pulse_stretcher #(.LEN_W(8), .PEND_W(2)) dut_s (.clk(clk), .rst(rst), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic pin;
        int   plen;
        int   glen;
        logic lvl;
        logic bsy;
        int   pend;
        logic ovf;
    } vec_t;
    vec_t vt[$];

    // reference model state: cycles of high/low still owed, queued events
    int hi_rem[2];
    int lo_rem[2];
    int q_m[2];
    int ovf_m[2];
    int maxp[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pin, input int plen, input int glen);
        ifa.pulse_in  = pin;
        ifa.pulse_len = plen[7:0];
        ifa.gap_len   = glen[7:0];
        ifb.pulse_in  = pin;
        ifb.pulse_len = plen[7:0];
        ifb.gap_len   = glen[7:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge of the behavioural model: the current high/gap obligation is
    // worked off first; once free, an available event starts a new pulse.
    task automatic model_step(input int i, input logic pin, input int plen, input int glen);
        int  avail;
        bit  free;
        bit  used;
        avail = q_m[i] + (pin ? 1 : 0);
        free  = 1'b0;
        used  = 1'b0;
        if (hi_rem[i] > 1) begin
            hi_rem[i]--;
        end else if (hi_rem[i] == 1) begin
            hi_rem[i] = 0;
            if (glen != 0) lo_rem[i] = glen;
            else           free = 1'b1;
        end else if (lo_rem[i] > 1) begin
            lo_rem[i]--;
        end else if (lo_rem[i] == 1) begin
            lo_rem[i] = 0;
            free = 1'b1;
        end else begin
            free = 1'b1;
        end
        if (free && avail > 0) begin
            hi_rem[i] = (plen == 0) ? 1 : plen;
            used = 1'b1;
        end
        ovf_m[i] = 0;
        if (pin && !used) begin
            if (q_m[i] == maxp[i]) ovf_m[i] = 1;
            else                   q_m[i]++;
        end else if (!pin && used) begin
            q_m[i]--;
        end
    endtask

    initial begin
        int rises_a;
        int rises_b;
        int ovf_a;
        int ovf_b;
        int peak_a;
        int peak_b;
        logic prev_a;
        logic prev_b;
        int plen_r;
        int glen_r;
        int dens;
        logic pin_r;

        drive(1'b0, 0, 0);
        maxp[0] = 15;
        maxp[1] = 3;

        // reset state
        tick();
        tick();
        chk("reset_level", ifa.level_out, 0);
        chk("reset_busy", ifa.busy, 0);
        chk("reset_pending", ifa.pending, 0);
        chk("reset_overflow", ifa.overflow, 0);
        chk("reset_s_pending", ifb.pending, 0);
        rst = 1'b1;
        tick();
        tick();

        // table: single event (3/2), zero length, mid-phase length changes
        vt.push_back('{1'b1, 3, 2, 1'b1, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 3, 2, 1'b1, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 3, 2, 1'b1, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 3, 2, 1'b0, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 3, 2, 1'b0, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 3, 2, 1'b0, 1'b0, 0, 1'b0});
        vt.push_back('{1'b0, 3, 2, 1'b0, 1'b0, 0, 1'b0});
        vt.push_back('{1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0});
        vt.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0});
        vt.push_back('{1'b1, 2, 1, 1'b1, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 7, 1, 1'b1, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 7, 1, 1'b0, 1'b1, 0, 1'b0});
        vt.push_back('{1'b0, 7, 9, 1'b0, 1'b0, 0, 1'b0});
        vt.push_back('{1'b0, 7, 9, 1'b0, 1'b0, 0, 1'b0});
        for (int r = 0; r < vt.size(); r++) begin
            drive(vt[r].pin, vt[r].plen, vt[r].glen);
            tick();
            chk($sformatf("vec%0d_level", r), ifa.level_out, vt[r].lvl);
            chk($sformatf("vec%0d_busy", r), ifa.busy, vt[r].bsy);
            chk($sformatf("vec%0d_pending", r), ifa.pending, vt[r].pend);
            chk($sformatf("vec%0d_overflow", r), ifa.overflow, vt[r].ovf);
        end

        // queued: three consecutive events, 4 high / 2 low
        for (int c = 0; c < 22; c++) begin
            drive(c < 3, 4, 2);
            tick();
            chk($sformatf("queue_c%0d_level", c), ifa.level_out, ((c % 6) < 4) && (c < 18));
            chk($sformatf("queue_c%0d_busy", c), ifa.busy, c < 18);
            chk($sformatf("queue_c%0d_pending", c), ifa.pending,
                (c == 1) ? 1 : (c >= 2 && c <= 5) ? 2 : (c >= 6 && c <= 11) ? 1 : 0);
            chk($sformatf("queue_c%0d_overflow", c), ifa.overflow, 0);
        end

        // back-to-back with no gap: 2 events x 2 cycles = 4 contiguous high
        for (int c = 0; c < 8; c++) begin
            drive(c < 2, 2, 0);
            tick();
            chk($sformatf("b2b_c%0d_level", c), ifa.level_out, c < 4);
            chk($sformatf("b2b_c%0d_pending", c), ifa.pending, (c == 1) ? 1 : 0);
        end

        // saturation: 5 events during the first 10-cycle high
        rises_a = 0; rises_b = 0; ovf_a = 0; ovf_b = 0; peak_a = 0; peak_b = 0;
        prev_a = 1'b0; prev_b = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive(c < 5, 10, 1);
            tick();
            if (ifa.level_out && !prev_a) rises_a++;
            if (ifb.level_out && !prev_b) rises_b++;
            prev_a = ifa.level_out;
            prev_b = ifb.level_out;
            if (ifa.overflow) ovf_a++;
            if (ifb.overflow) ovf_b++;
            if (int'(ifa.pending) > peak_a) peak_a = int'(ifa.pending);
            if (int'(ifb.pending) > peak_b) peak_b = int'(ifb.pending);
            chk($sformatf("sat_c%0d_overflow", c), ifb.overflow, c == 4);
        end
        chk("sat_s_pulses", rises_b, 4);
        chk("sat_s_overflows", ovf_b, 1);
        chk("sat_s_peak", peak_b, 3);
        chk("sat_pulses", rises_a, 5);
        chk("sat_overflows", ovf_a, 0);
        chk("sat_peak", peak_a, 4);
        chk("sat_end_busy", ifa.busy, 0);

        // asynchronous reset mid-HIGH with two events queued
        drive(1'b1, 10, 0);
        tick();
        tick();
        tick();
        drive(1'b0, 10, 0);
        chk("rst_pre_pending", ifa.pending, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_level", ifa.level_out, 0);
        chk("rst_async_busy", ifa.busy, 0);
        chk("rst_async_pending", ifa.pending, 0);
        tick();
        tick();
        rst = 1'b1;
        prev_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ifa.level_out || ifa.busy) prev_a = 1'b1;
        end
        chk("rst_no_replay", prev_a, 0);

        // randomized run against the behavioural model
        for (int i = 0; i < 2; i++) begin
            hi_rem[i] = 0; lo_rem[i] = 0; q_m[i] = 0; ovf_m[i] = 0;
        end
        plen_r = 2; glen_r = 1; dens = 20;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 500) == 0) dens = $urandom_range(5, 80);
            if ($urandom_range(0, 15) == 0) begin
                plen_r = $urandom_range(0, 5);
                glen_r = $urandom_range(0, 3);
            end
            pin_r = ($urandom_range(0, 99) < dens);
            drive(pin_r, plen_r, glen_r);
            model_step(0, pin_r, plen_r, glen_r);
            model_step(1, pin_r, plen_r, glen_r);
            tick();
            chk("rand_a_level", ifa.level_out, hi_rem[0] > 0);
            chk("rand_a_busy", ifa.busy, (hi_rem[0] > 0) || (lo_rem[0] > 0));
            chk("rand_a_pending", ifa.pending, q_m[0]);
            chk("rand_a_overflow", ifa.overflow, ovf_m[0]);
            chk("rand_b_level", ifb.level_out, hi_rem[1] > 0);
            chk("rand_b_busy", ifb.busy, (hi_rem[1] > 0) || (lo_rem[1] > 0));
            chk("rand_b_pending", ifb.pending, q_m[1]);
            chk("rand_b_overflow", ifb.overflow, ovf_m[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
